// File: rtl/mips_multicycle_ctrl.sv
// Multicycle control FSM for the MIPS core.
// Sequences the shared ALU, unified memory port, IR, register file and PC through
// fetch / decode / execute / memory / writeback. Memory states wait on mem_ready and
// abort after MEM_TIMEOUT consecutive not-ready cycles.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   opcode, funct       IR fields, captured in DECODE
//   Zero                ALU compare flag, gates pc_write in EXEC_BR
//   mem_ready           memory access completes this cycle
//   ALUSrc, ALUCtrl     ALU operand select and operation
//   mem_read/mem_write  memory requests, IorD selects PC (0) or ALU result (1) address
//   ir_write, reg_write, RegDst, MemtoReg, pc_write, pc_src   datapath enables/selects
//   instr_done, illegal_op, mem_timeout                       one-cycle status pulses
module mips_multicycle_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       ALUSrc,
  output logic [3:0] ALUCtrl,
  output logic       mem_read,
  output logic       mem_write,
  output logic       IorD,
  output logic       ir_write,
  output logic       reg_write,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       instr_done,
  output logic       illegal_op,
  output logic       mem_timeout
);

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpBne   = 6'b000101;
  localparam logic [5:0] OpJ     = 6'b000010;

  localparam logic [3:0] AluAdd = 4'b0000;
  localparam logic [3:0] AluBeq = 4'b0111;
  localparam logic [3:0] AluBne = 4'b1000;

  // The limit is hit on the MEM_TIMEOUT-th not-ready cycle, i.e. while the count still
  // holds MEM_TIMEOUT-1.
  localparam logic [3:0] WaitLimit = 4'(MEM_TIMEOUT - 1);

  typedef enum logic [3:0] {
    StFetch, StDecode, StExecR, StExecAddr, StExecAddi, StExecBr, StMemRd,
    StMemWr, StWbR, StWbMem, StWbI, StJump, StErr
  } state_e;

  state_e     state_q, state_d;
  logic [5:0] op_q, funct_q;
  logic [3:0] wait_q;
  logic [3:0] r_ctrl;
  logic       r_ok;
  logic       mem_state;
  logic       timeout_hit;

  // R-type funct decode from the latched IR field
  always_comb begin
    r_ok   = 1'b1;
    r_ctrl = AluAdd;
    case (funct_q)
      6'b100000: r_ctrl = 4'b0000;
      6'b100010: r_ctrl = 4'b0001;
      6'b100100: r_ctrl = 4'b0010;
      6'b100101: r_ctrl = 4'b0011;
      6'b000000: r_ctrl = 4'b0100;
      6'b000010: r_ctrl = 4'b0101;
      6'b101010: r_ctrl = 4'b0110;
      default:   r_ok   = 1'b0;
    endcase
  end

  assign mem_state   = state_q inside {StFetch, StMemRd, StMemWr};
  assign timeout_hit = mem_state && !mem_ready && (wait_q == WaitLimit);

  always_comb begin
    state_d     = state_q;
    ALUSrc      = 1'b0;
    ALUCtrl     = AluAdd;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    IorD        = 1'b0;
    ir_write    = 1'b0;
    reg_write   = 1'b0;
    RegDst      = 1'b0;
    MemtoReg    = 1'b0;
    pc_write    = 1'b0;
    pc_src      = 2'b00;
    instr_done  = 1'b0;
    illegal_op  = 1'b0;
    mem_timeout = 1'b0;

    unique case (state_q)
      StFetch: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = StDecode;
        end else if (timeout_hit) begin
          mem_timeout = 1'b1;
        end
      end
      StDecode: begin
        // Dispatch on the live IR field; the latched copy is valid from the next cycle
        case (opcode)
          OpRtype:     state_d = StExecR;
          OpLw, OpSw:  state_d = StExecAddr;
          OpAddi:      state_d = StExecAddi;
          OpBeq, OpBne: state_d = StExecBr;
          OpJ:         state_d = StJump;
          default:     state_d = StErr;
        endcase
      end
      StExecR: begin
        ALUCtrl = r_ok ? r_ctrl : AluAdd;
        state_d = r_ok ? StWbR : StErr;
      end
      StExecAddr: begin
        ALUSrc  = 1'b1;
        state_d = (op_q == OpSw) ? StMemWr : StMemRd;
      end
      StExecAddi: begin
        ALUSrc  = 1'b1;
        state_d = StWbI;
      end
      StExecBr: begin
        ALUCtrl    = (op_q == OpBne) ? AluBne : AluBeq;
        pc_src     = 2'b01;
        pc_write   = Zero;
        instr_done = 1'b1;
        state_d    = StFetch;
      end
      StMemRd, StMemWr: begin
        mem_read  = (state_q == StMemRd);
        mem_write = (state_q == StMemWr);
        IorD      = 1'b1;
        ALUSrc    = 1'b1;
        if (mem_ready) begin
          instr_done = (state_q == StMemWr);
          state_d    = (state_q == StMemWr) ? StFetch : StWbMem;
        end else if (timeout_hit) begin
          mem_timeout = 1'b1;
          state_d     = StFetch;
        end
      end
      StWbR: begin
        reg_write  = 1'b1;
        RegDst     = 1'b1;
        ALUCtrl    = r_ctrl;
        instr_done = 1'b1;
        state_d    = StFetch;
      end
      StWbI: begin
        reg_write  = 1'b1;
        ALUSrc     = 1'b1;
        instr_done = 1'b1;
        state_d    = StFetch;
      end
      StWbMem: begin
        reg_write  = 1'b1;
        MemtoReg   = 1'b1;
        instr_done = 1'b1;
        state_d    = StFetch;
      end
      StJump: begin
        pc_write   = 1'b1;
        pc_src     = 2'b10;
        instr_done = 1'b1;
        state_d    = StFetch;
      end
      StErr: begin
        illegal_op = 1'b1;
        state_d    = StFetch;
      end
      default: state_d = StFetch;
    endcase

    // Reset state is FETCH, which would otherwise request memory; hold everything quiet
    if (rst) begin
      ALUSrc      = 1'b0;
      ALUCtrl     = AluAdd;
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      IorD        = 1'b0;
      ir_write    = 1'b0;
      reg_write   = 1'b0;
      RegDst      = 1'b0;
      MemtoReg    = 1'b0;
      pc_write    = 1'b0;
      pc_src      = 2'b00;
      instr_done  = 1'b0;
      illegal_op  = 1'b0;
      mem_timeout = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StFetch;
      op_q    <= '0;
      funct_q <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StDecode) begin
        op_q    <= opcode;
        funct_q <= funct;
      end
      // Any state change (including FETCH re-entry on timeout) restarts the wait count
      if ((state_d != state_q) || timeout_hit) begin
        wait_q <= '0;
      end else if (mem_state && !mem_ready) begin
        wait_q <= wait_q + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl. Each instruction is described as a
// list of phases (fixed one-cycle phases and memory phases that wait on mem_ready);
// expected output words are derived per cycle from that list.
module tb_mips_multicycle_ctrl;

  localparam int unsigned MemTimeout = 15;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode, funct;
  logic       Zero, mem_ready;
  logic       ALUSrc, mem_read, mem_write, IorD, ir_write, reg_write, RegDst, MemtoReg;
  logic       pc_write, instr_done, illegal_op, mem_timeout;
  logic [3:0] ALUCtrl;
  logic [1:0] pc_src;

  always #5 clk = ~clk;

  mips_multicycle_ctrl #(.MEM_TIMEOUT(MemTimeout)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .Zero(Zero),
    .mem_ready(mem_ready), .ALUSrc(ALUSrc), .ALUCtrl(ALUCtrl), .mem_read(mem_read),
    .mem_write(mem_write), .IorD(IorD), .ir_write(ir_write), .reg_write(reg_write),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .pc_write(pc_write), .pc_src(pc_src),
    .instr_done(instr_done), .illegal_op(illegal_op), .mem_timeout(mem_timeout)
  );

  // Output word layout
  logic [17:0] got_w;
  assign got_w = {ALUSrc, ALUCtrl, mem_read, mem_write, IorD, ir_write, reg_write, RegDst,
                  MemtoReg, pc_write, pc_src, instr_done, illegal_op, mem_timeout};

  localparam logic [17:0] WSrc  = 18'h20000;
  localparam logic [17:0] WRd   = 18'h01000;
  localparam logic [17:0] WWr   = 18'h00800;
  localparam logic [17:0] WIord = 18'h00400;
  localparam logic [17:0] WIrw  = 18'h00200;
  localparam logic [17:0] WRegw = 18'h00100;
  localparam logic [17:0] WRdst = 18'h00080;
  localparam logic [17:0] WM2r  = 18'h00040;
  localparam logic [17:0] WPcw  = 18'h00020;
  localparam logic [17:0] WPsJ  = 18'h00010;
  localparam logic [17:0] WPsBr = 18'h00008;
  localparam logic [17:0] WDone = 18'h00004;
  localparam logic [17:0] WIll  = 18'h00002;
  localparam logic [17:0] WTmo  = 18'h00001;

  // R-type funct codes; the ALUCtrl value is the position in this list
  localparam logic [5:0] RFn [7] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h00, 6'h02, 6'h2a};

  typedef struct {
    bit          is_mem;
    bit          br;
    logic [17:0] wait_w;
    logic [17:0] done_w;
  } phase_t;

  typedef struct {
    string      name;
    logic [5:0] op;
    logic [5:0] fn;
    int         zero;
    int         cyc;
    int         regw;
    int         pcw;
    int         ill;
    int         done;
  } vec_t;

  phase_t prog[$];
  vec_t   vecs[$];
  bit     ready_script[$];
  int     ready_pct = 100;
  int     zero_mode = -1;
  int     n_checks  = 0;
  int     n_errors  = 0;

  function automatic logic [17:0] ctl(input logic [3:0] c);
    return {1'b0, c, 13'b0};
  endfunction

  function automatic bit r_map(input logic [5:0] fn, output logic [3:0] c);
    c = 4'h0;
    for (int i = 0; i < 7; i++) begin
      if (RFn[i] == fn) begin
        c = 4'(i);
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic step(input logic [17:0] exp, input string name);
    @(negedge clk);
    chk(name, 32'(got_w), 32'(exp));
    @(posedge clk);
    #1;
  endtask

  task automatic add(input bit m, input bit b, input logic [17:0] w, input logic [17:0] d);
    phase_t ph;
    ph.is_mem = m;
    ph.br     = b;
    ph.wait_w = w;
    ph.done_w = d;
    prog.push_back(ph);
  endtask

  task automatic build_prog(input logic [5:0] op, input logic [5:0] fn);
    logic [3:0] c;
    prog.delete();
    add(1'b1, 1'b0, WRd, WRd | WIrw | WPcw);  // fetch
    add(1'b0, 1'b0, '0, '0);                  // decode
    case (op)
      6'h00: begin
        if (r_map(fn, c)) begin
          add(1'b0, 1'b0, '0, ctl(c));
          add(1'b0, 1'b0, '0, WRegw | WRdst | WDone | ctl(c));
        end else begin
          add(1'b0, 1'b0, '0, '0);
          add(1'b0, 1'b0, '0, WIll);
        end
      end
      6'h23: begin
        add(1'b0, 1'b0, '0, WSrc);
        add(1'b1, 1'b0, WRd | WIord | WSrc, WRd | WIord | WSrc);
        add(1'b0, 1'b0, '0, WRegw | WM2r | WDone);
      end
      6'h2b: begin
        add(1'b0, 1'b0, '0, WSrc);
        add(1'b1, 1'b0, WWr | WIord | WSrc, WWr | WIord | WSrc | WDone);
      end
      6'h08: begin
        add(1'b0, 1'b0, '0, WSrc);
        add(1'b0, 1'b0, '0, WRegw | WSrc | WDone);
      end
      6'h04:   add(1'b0, 1'b1, '0, ctl(4'h7) | WPsBr | WDone);
      6'h05:   add(1'b0, 1'b1, '0, ctl(4'h8) | WPsBr | WDone);
      6'h02:   add(1'b0, 1'b0, '0, WPcw | WPsJ | WDone);
      default: add(1'b0, 1'b0, '0, WIll);
    endcase
  endtask

  task automatic next_ready(output bit r);
    if (ready_script.size() > 0) r = ready_script.pop_front();
    else r = (int'($urandom_range(0, 99)) < ready_pct);
  endtask

  task automatic script(input bit lead, input int zeros, input bit tail);
    ready_script.delete();
    if (lead) ready_script.push_back(1'b1);
    for (int i = 0; i < zeros; i++) ready_script.push_back(1'b0);
    if (tail) ready_script.push_back(1'b1);
  endtask

  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input string tag,
                           output int cyc, output int n_regw, output int n_pcw,
                           output int n_ill, output int n_tmo, output int n_done,
                           output int n_maddr);
    logic [17:0] exp;
    bit          rdy, fin, aborted;
    int          waits;
    build_prog(op, fn);
    cyc = 0; n_regw = 0; n_pcw = 0; n_ill = 0; n_tmo = 0; n_done = 0; n_maddr = 0;
    aborted = 1'b0;
    for (int p = 0; p < prog.size() && !aborted; p++) begin
      waits = 0;
      fin   = 1'b0;
      while (!fin) begin
        // IR fields are only meaningful in the decode cycle; garbage elsewhere
        opcode = (p == 1) ? op : 6'($urandom);
        funct  = (p == 1) ? fn : 6'($urandom);
        Zero   = (zero_mode < 0) ? 1'($urandom) : 1'(zero_mode);
        if (prog[p].is_mem) begin
          next_ready(rdy);
          if (rdy) begin
            exp = prog[p].done_w;
            fin = 1'b1;
          end else if (waits == MemTimeout - 1) begin
            exp     = prog[p].wait_w | WTmo;
            fin     = 1'b1;
            aborted = 1'b1;
          end else begin
            exp = prog[p].wait_w;
            waits++;
          end
        end else begin
          rdy = 1'($urandom);
          exp = prog[p].done_w | ((prog[p].br && Zero) ? WPcw : 18'h0);
          fin = 1'b1;
        end
        mem_ready = rdy;
        @(negedge clk);
        chk($sformatf("%s cyc%0d", tag, cyc), 32'(got_w), 32'(exp));
        n_regw  += int'(reg_write);
        n_pcw   += int'(pc_write);
        n_ill   += int'(illegal_op);
        n_tmo   += int'(mem_timeout);
        n_done  += int'(instr_done);
        n_maddr += int'((mem_read | mem_write) & IorD);
        cyc++;
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic addv(input string name, input logic [5:0] op, input logic [5:0] fn,
                      input int zero, input int cyc, input int regw, input int pcw,
                      input int ill, input int done);
    vec_t v;
    v.name = name; v.op = op; v.fn = fn; v.zero = zero; v.cyc = cyc;
    v.regw = regw; v.pcw = pcw; v.ill = ill; v.done = done;
    vecs.push_back(v);
  endtask

  initial begin
    int         cyc, regw, pcw, ill, tmo, dn, maddr;
    int         pcts[4];
    logic [5:0] rop, rfn;
    pcts = '{100, 70, 40, 5};

    //   name        op     fn     zero cyc regw pcw ill done
    addv("add",     6'h00, 6'h20, -1,  4,  1,   1,  0,  1);
    addv("sub",     6'h00, 6'h22, -1,  4,  1,   1,  0,  1);
    addv("and",     6'h00, 6'h24, -1,  4,  1,   1,  0,  1);
    addv("or",      6'h00, 6'h25, -1,  4,  1,   1,  0,  1);
    addv("sll",     6'h00, 6'h00, -1,  4,  1,   1,  0,  1);
    addv("srl",     6'h00, 6'h02, -1,  4,  1,   1,  0,  1);
    addv("slt",     6'h00, 6'h2a, -1,  4,  1,   1,  0,  1);
    addv("badfn",   6'h00, 6'h08, -1,  4,  0,   1,  1,  0);
    addv("lw",      6'h23, 6'h11, -1,  5,  1,   1,  0,  1);
    addv("sw",      6'h2b, 6'h11, -1,  4,  0,   1,  0,  1);
    addv("addi",    6'h08, 6'h3f, -1,  4,  1,   1,  0,  1);
    addv("beq_z1",  6'h04, 6'h00,  1,  3,  0,   2,  0,  1);
    addv("beq_z0",  6'h04, 6'h00,  0,  3,  0,   1,  0,  1);
    addv("bne_z1",  6'h05, 6'h00,  1,  3,  0,   2,  0,  1);
    addv("j",       6'h02, 6'h00, -1,  3,  0,   2,  0,  1);
    addv("badop",   6'h3f, 6'h20, -1,  3,  0,   1,  1,  0);

    // Reset: outputs held at zero even with a ready memory
    rst = 1'b1; mem_ready = 1'b1; opcode = 6'h23; funct = 6'h0; Zero = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    step('0, "reset_outputs");
    rst = 1'b0; mem_ready = 1'b0;
    step(WRd, "fetch_after_reset");

    foreach (vecs[i]) begin
      zero_mode = vecs[i].zero;
      run_instr(vecs[i].op, vecs[i].fn, vecs[i].name, cyc, regw, pcw, ill, tmo, dn, maddr);
      chk({vecs[i].name, "_cycles"}, cyc, vecs[i].cyc);
      chk({vecs[i].name, "_regw"}, regw, vecs[i].regw);
      chk({vecs[i].name, "_pcw"}, pcw, vecs[i].pcw);
      chk({vecs[i].name, "_ill"}, ill, vecs[i].ill);
      chk({vecs[i].name, "_done"}, dn, vecs[i].done);
    end
    zero_mode = -1;

    // lw with three not-ready cycles in MEM_RD
    script(1'b1, 3, 1'b1);
    run_instr(6'h23, 6'h00, "lw_stall", cyc, regw, pcw, ill, tmo, dn, maddr);
    chk("lw_stall_cycles", cyc, 8);
    chk("lw_stall_memaddr", maddr, 4);
    chk("lw_stall_done", dn, 1);

    // sw never ready: timeout on the 15th wait cycle
    script(1'b1, 15, 1'b0);
    run_instr(6'h2b, 6'h00, "sw_tmo", cyc, regw, pcw, ill, tmo, dn, maddr);
    chk("sw_tmo_cycles", cyc, 18);
    chk("sw_tmo_pulse", tmo, 1);
    chk("sw_tmo_done", dn, 0);

    // sw ready exactly on the 15th cycle: completes, no timeout
    script(1'b1, 14, 1'b1);
    run_instr(6'h2b, 6'h00, "sw_edge", cyc, regw, pcw, ill, tmo, dn, maddr);
    chk("sw_edge_cycles", cyc, 18);
    chk("sw_edge_tmo", tmo, 0);
    chk("sw_edge_done", dn, 1);

    // Fetch that never completes
    script(1'b0, 15, 1'b0);
    run_instr(6'h02, 6'h00, "fetch_tmo", cyc, regw, pcw, ill, tmo, dn, maddr);
    chk("fetch_tmo_cycles", cyc, 15);
    chk("fetch_tmo_pulse", tmo, 1);
    chk("fetch_tmo_pcw", pcw, 0);

    // Reset asserted while a store is waiting
    ready_script.delete();
    mem_ready = 1'b1; opcode = 6'h3f;
    step(WRd | WIrw | WPcw, "rs_fetch");
    opcode = 6'h2b;
    step('0, "rs_decode");
    opcode = 6'h3f;
    step(WSrc, "rs_exec");
    mem_ready = 1'b0;
    step(WWr | WIord | WSrc, "rs_memwr");
    mem_ready = 1'b1; rst = 1'b1;
    step('0, "rs_in_reset");
    rst = 1'b0; mem_ready = 1'b0;
    step(WRd, "rs_fetch_after");
    script(1'b1, 0, 1'b0);
    run_instr(6'h02, 6'h00, "rs_resume", cyc, regw, pcw, ill, tmo, dn, maddr);

    // Randomized instruction stream with varying memory latency
    for (int n = 0; n < 300; n++) begin
      ready_pct = pcts[$urandom_range(0, 3)];
      rfn = 6'($urandom);
      case ($urandom_range(0, 9))
        0, 1, 2: begin
          rop = 6'h00;
          if ($urandom_range(0, 3) != 0) rfn = RFn[$urandom_range(0, 6)];
        end
        3:       rop = 6'h23;
        4:       rop = 6'h2b;
        5:       rop = 6'h08;
        6:       rop = 6'h04;
        7:       rop = 6'h05;
        8:       rop = 6'h02;
        default: rop = 6'($urandom);
      endcase
      run_instr(rop, rfn, "rand", cyc, regw, pcw, ill, tmo, dn, maddr);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
